buscador_caracter: RTL and testbench

Sequential lookup engine that compares one received character against a programmable table of reference characters and returns the index of the first matching entry. It replaces single-pair equality checking in the Morse transmitter path. The character decoder hands it an ASCII code, and the returned index addresses the Morse pattern ROM. The table is written at run time, and the search scans one entry per clock behind a valid/ready handshake.

---
 rtl/buscador_caracter_if.sv | 43 ++++
 rtl/buscador_caracter.sv | 153 +++++++++++++++
 tb/tb_buscador_caracter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/buscador_caracter_if.sv
// Handshake and table-write bundle for buscador_caracter.
// Latency: none, wires only.
// Backpressure: carries the in_valid/in_ready and out_valid/out_ready pairs.
interface buscador_caracter_if #(
  parameter int ANCHO       = 7,
  parameter int PROFUNDIDAD = 36
);
  localparam int IW = $clog2(PROFUNDIDAD);

  // Table write port
  logic             wr_en;
  logic [IW-1:0]    wr_dir;
  logic [ANCHO-1:0] wr_dato;

  // Query side
  logic             in_valid;
  logic             in_ready;
  logic [ANCHO-1:0] in_caracter;

  // Result side
  logic             out_valid;
  logic             out_ready;
  logic [IW-1:0]    out_indice;
  logic             out_encontrado;

  // Producer of queries and table writes, consumer of results
  modport master (
    output wr_en, wr_dir, wr_dato,
    output in_valid, in_caracter,
    input  in_ready,
    input  out_valid, out_indice, out_encontrado,
    output out_ready
  );

  // The lookup engine itself
  modport slave (
    input  wr_en, wr_dir, wr_dato,
    input  in_valid, in_caracter,
    output in_ready,
    output out_valid, out_indice, out_encontrado,
    input  out_ready
  );
endinterface

// File: rtl/buscador_caracter.sv
// Character lookup: scans a run-time written table one entry per clock, returns first matching index.
// Latency: hit at entry k -> out_valid k+1 edges after acceptance; miss -> PROFUNDIDAD edges.
// Backpressure: result held in LISTO until out_ready; in_ready low from acceptance until result taken.
// Optional case folding ('a'..'z' compared as 'A'..'Z') enabled by macro BUSCADOR_MAYUSCULAS_EN.
module buscador_caracter #(
  parameter int ANCHO       = 7,
  parameter int PROFUNDIDAD = 36
) (
  input  logic               clk,
  input  logic               rst,
  buscador_caracter_if.slave bus
);

  localparam int            IW     = $clog2(PROFUNDIDAD);
  localparam logic [IW-1:0] ULTIMO = IW'(PROFUNDIDAD - 1);

  typedef enum logic [1:0] {
    LIBRE = 2'd0,
    BUSCA = 2'd1,
    LISTO = 2'd2
  } estado_t;

  // Normalisation applied to both sides of every comparison. Only the low
  // seven bits are looked at; any wider bits pass through untouched.
  function automatic logic [ANCHO-1:0] plegar(input logic [ANCHO-1:0] c);
    logic [ANCHO-1:0] r;
    r = c;
`ifdef BUSCADOR_MAYUSCULAS_EN
    if ((c[6:0] >= 7'h61) && (c[6:0] <= 7'h7A)) begin
      r[5] = 1'b0;
    end
`endif
    return r;
  endfunction

  // Control and datapath state
  estado_t          estado_q,      estado_d;
  logic [IW-1:0]    puntero_q,     puntero_d;
  logic [ANCHO-1:0] caracter_q,    caracter_d;
  logic [IW-1:0]    indice_q,      indice_d;
  logic             encontrado_q,  encontrado_d;
  logic             out_valid_q,   out_valid_d;
  logic             in_ready_q,    in_ready_d;

  // Reference table: data has no reset, only the valid bits do
  logic [ANCHO-1:0]       tabla_dat_q [PROFUNDIDAD];
  logic [ANCHO-1:0]       tabla_dat_d [PROFUNDIDAD];
  logic [PROFUNDIDAD-1:0] tabla_vld_q, tabla_vld_d;

  logic aceptar;
  logic coincide;

  // A query is taken only while idle and advertising ready
  assign aceptar = bus.in_valid && in_ready_q && (estado_q == LIBRE);

  // Compare against registered table contents, so a same-cycle write to the
  // entry under test is only seen from the following cycle.
  assign coincide = tabla_vld_q[puntero_q] &&
                    (plegar(tabla_dat_q[puntero_q]) == plegar(caracter_q));

  // Table write decode: addresses at or beyond PROFUNDIDAD match no entry
  always_comb begin
    tabla_dat_d = tabla_dat_q;
    tabla_vld_d = tabla_vld_q;
    for (int i = 0; i < PROFUNDIDAD; i++) begin
      if (bus.wr_en && (bus.wr_dir == IW'(i))) begin
        tabla_dat_d[i] = bus.wr_dato;
        tabla_vld_d[i] = 1'b1;
      end
    end
  end

  // Search FSM next state and registered-output next values
  always_comb begin
    estado_d     = estado_q;
    puntero_d    = puntero_q;
    caracter_d   = caracter_q;
    indice_d     = indice_q;
    encontrado_d = encontrado_q;

    case (estado_q)
      LIBRE: begin
        if (aceptar) begin
          caracter_d = bus.in_caracter;
          puntero_d  = '0;
          estado_d   = BUSCA;
        end
      end

      BUSCA: begin
        if (coincide) begin
          indice_d     = puntero_q;
          encontrado_d = 1'b1;
          estado_d     = LISTO;
        end else if (puntero_q == ULTIMO) begin
          indice_d     = '0;
          encontrado_d = 1'b0;
          estado_d     = LISTO;
        end else begin
          puntero_d = puntero_q + IW'(1);
        end
      end

      LISTO: begin
        if (bus.out_ready) begin
          estado_d = LIBRE;
        end
      end

      default: begin
        estado_d = LIBRE;
      end
    endcase

    // Handshake outputs are decoded from the next state so they are flops
    out_valid_d = (estado_d == LISTO);
    in_ready_d  = (estado_d == LIBRE);
  end

  // Control, result and valid-bit registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q     <= LIBRE;
      puntero_q    <= '0;
      caracter_q   <= '0;
      indice_q     <= '0;
      encontrado_q <= 1'b0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      tabla_vld_q  <= '0;
    end else begin
      estado_q     <= estado_d;
      puntero_q    <= puntero_d;
      caracter_q   <= caracter_d;
      indice_q     <= indice_d;
      encontrado_q <= encontrado_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      tabla_vld_q  <= tabla_vld_d;
    end
  end

  // Table data storage, meaningful only where the valid bit is set
  always_ff @(posedge clk) begin
    tabla_dat_q <= tabla_dat_d;
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_indice     = indice_q;
  assign bus.out_encontrado = encontrado_q;

endmodule

// File: tb/tb_buscador_caracter.sv
// Directed bench for buscador_caracter with a result scoreboard.
// Expected index/found/latency pushed at query acceptance, popped when out_valid rises.
// Covers reset, hits, misses, duplicates, backpressure, same-cycle write, mid-search reset, folding.
module tb_buscador_caracter;

  localparam int ANCHO       = 7;
  localparam int PROFUNDIDAD = 36;
  localparam int IW          = $clog2(PROFUNDIDAD);

  typedef struct {
    logic [IW-1:0] idx;
    logic          enc;
    int            lat;
  } esperado_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  esperado_t sb[$];

  buscador_caracter_if #(.ANCHO(ANCHO), .PROFUNDIDAD(PROFUNDIDAD)) bus ();

  buscador_caracter #(.ANCHO(ANCHO), .PROFUNDIDAD(PROFUNDIDAD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic paso();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_y_verifica(input string tag);
    rst = 1'b1;
    paso();
    chk({tag, "_rst_in_ready"},   32'(bus.in_ready),       32'd0);
    chk({tag, "_rst_out_valid"},  32'(bus.out_valid),      32'd0);
    chk({tag, "_rst_out_indice"}, 32'(bus.out_indice),     32'd0);
    chk({tag, "_rst_out_enc"},    32'(bus.out_encontrado), 32'd0);
    rst = 1'b0;
    paso();
    chk({tag, "_post_rst_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic escribir(input logic [IW-1:0] dir, input logic [ANCHO-1:0] dato);
    bus.wr_en   = 1'b1;
    bus.wr_dir  = dir;
    bus.wr_dato = dato;
    paso();
    bus.wr_en   = 1'b0;
  endtask

  // One query: optional backpressure hold and optional table write issued
  // 'wr_at' edges after acceptance (so it lands on edge wr_at+1).
  task automatic consulta(input string tag, input logic [ANCHO-1:0] c,
                          input logic enc, input logic [IW-1:0] idx, input int lat_esp,
                          input int hold, input int wr_at,
                          input logic [IW-1:0] wdir, input logic [ANCHO-1:0] wdat);
    esperado_t e;
    int lat;
    int espera;
    bus.out_ready = (hold == 0);
    espera = 0;
    while (bus.in_ready !== 1'b1 && espera < 20) begin
      paso();
      espera++;
    end
    chk({tag, "_in_ready_before"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid    = 1'b1;
    bus.in_caracter = c;
    paso();
    bus.in_valid    = 1'b0;
    bus.in_caracter = ~c;
    sb.push_back('{idx: idx, enc: enc, lat: lat_esp});
    chk({tag, "_in_ready_after_accept"}, 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 400) begin
      if (lat == wr_at) begin
        bus.wr_en   = 1'b1;
        bus.wr_dir  = wdir;
        bus.wr_dato = wdat;
      end
      paso();
      lat++;
      bus.wr_en = 1'b0;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, 32'(lat),                 32'(e.lat));
    chk({tag, "_indice"},  32'(bus.out_indice),      32'(e.idx));
    chk({tag, "_enc"},     32'(bus.out_encontrado),  32'(e.enc));
    for (int h = 0; h < hold; h++) begin
      paso();
      chk({tag, "_hold_valid"},    32'(bus.out_valid),      32'd1);
      chk({tag, "_hold_in_ready"}, 32'(bus.in_ready),       32'd0);
      chk({tag, "_hold_indice"},   32'(bus.out_indice),     32'(e.idx));
      chk({tag, "_hold_enc"},      32'(bus.out_encontrado), 32'(e.enc));
    end
    bus.out_ready = 1'b1;
    paso();
    chk({tag, "_valid_dropped"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready_back"}, 32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b0;
    bus.wr_en       = 1'b0;
    bus.wr_dir      = '0;
    bus.wr_dato     = '0;
    bus.in_valid    = 1'b0;
    bus.in_caracter = '0;
    bus.out_ready   = 1'b1;
    paso();

    // Reset values, then a query against the empty table misses
    reset_y_verifica("inicio");
    consulta("vacia", 7'h41, 1'b0, '0, PROFUNDIDAD, 0, -1, '0, '0);

    // Alphabet in entries 0..25, 'E' found at 4
    for (int i = 0; i < 26; i++) begin
      escribir(IW'(i), 7'(8'h41 + i));
    end
    consulta("letra_E", 7'h45, 1'b1, 6'd4, 5, 0, -1, '0, '0);
    consulta("letra_Z", 7'h5A, 1'b1, 6'd25, 26, 0, -1, '0, '0);

    // Duplicates: lowest index wins, with four cycles of backpressure
    escribir(6'd3, 7'h53);
    escribir(6'd9, 7'h53);
    consulta("duplicado", 7'h53, 1'b1, 6'd3, 4, 4, -1, '0, '0);

    // Out-of-range write is dropped; then same-cycle write to compared entry
    reset_y_verifica("r2");
    escribir(6'd40, 7'h50);
    consulta("dir_fuera", 7'h50, 1'b0, '0, PROFUNDIDAD, 0, -1, '0, '0);
    consulta("escr_misma", 7'h4B, 1'b0, '0, PROFUNDIDAD, 0, 7, 6'd7, 7'h4B);
    consulta("escr_luego", 7'h4B, 1'b1, 6'd7, 8, 0, -1, '0, '0);

    // Reset while scanning at pointer 5 aborts and invalidates the table
    bus.in_valid    = 1'b1;
    bus.in_caracter = 7'h4B;
    paso();
    bus.in_valid    = 1'b0;
    chk("abort_accepted", 32'(bus.in_ready), 32'd0);
    repeat (5) paso();
    chk("abort_no_valid_yet", 32'(bus.out_valid), 32'd0);
    reset_y_verifica("abort");
    consulta("tras_abort", 7'h4B, 1'b0, '0, PROFUNDIDAD, 0, -1, '0, '0);

    // Case handling: exact match always, lower-case only with folding
    escribir(6'd2, 7'h4D);
    consulta("exacta_M", 7'h4D, 1'b1, 6'd2, 3, 0, -1, '0, '0);
`ifdef BUSCADOR_MAYUSCULAS_EN
    consulta("minus_m", 7'h6D, 1'b1, 6'd2, 3, 0, -1, '0, '0);
`else
    consulta("minus_m", 7'h6D, 1'b0, '0, PROFUNDIDAD, 0, -1, '0, '0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
